enoc_node_interface: RTL and testbench

- Node-side endpoint of the ENoC valid/enable link.
- TX half: accepts payloads from a local traffic source, buffers them, builds packet_t, and drives the network input port.
- RX half: accepts packets from the network output port and hands them to a local sink. It also keeps counters, latency and misroute status.
- One instance per node, directly attached to network port NODE_ID.

---
 rtl/enoc_pkg.sv | 40 ++++
 rtl/enoc_sync_fifo.sv | 76 +++++++
 rtl/enoc_node_interface.sv | 157 +++++++++++++++
 tb/tb_enoc_node_interface.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enoc_pkg.sv
// ---------------------------------------------------------------------------
// enoc_pkg
// Shared types and constants for the ENoC node interface.
//   DATA_WIDTH / ADDR_WIDTH / TS_WIDTH : link field widths
//   packet_t    : {data, source, dest, timestamp}, data in the MSBs
//   rx_state_e  : RX holding-register state, also exported for debug
//   depth_log2  : pointer width for a power-of-two FIFO depth
// ---------------------------------------------------------------------------
package enoc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 6;
    localparam int TS_WIDTH   = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] source;
        logic [ADDR_WIDTH-1:0] dest;
        logic [TS_WIDTH-1:0]   timestamp;
    } packet_t;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

    // Smallest r with 2**r >= depth. Bounded loop so it elaborates as a
    // constant function.
    function automatic int depth_log2(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/enoc_sync_fifo.sv
// ---------------------------------------------------------------------------
// enoc_sync_fifo
// Single-clock packet_t FIFO, DEPTH a power of two (>= 2).
//   clk, reset   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din    : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   dout         : current head entry (stale data when empty)
//   full, empty  : occupancy flags, pure functions of registered state
// Simultaneous push and pop leaves the occupancy unchanged.
// ---------------------------------------------------------------------------
module enoc_sync_fifo
    import enoc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  packet_t din,
    input  logic    pop,
    output packet_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = depth_log2(DEPTH);

    packet_t       mem_q [DEPTH];
    packet_t       mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/enoc_node_interface.sv
// ---------------------------------------------------------------------------
// enoc_node_interface
// Node-side endpoint of the ENoC valid/enable link.
//   clk, reset                       : clock, async active-high reset
//   src_payload/src_dest/src_val/src_rdy : local traffic source (TX in)
//   net_tx_data/net_tx_val/net_tx_en : to network input port NODE_ID
//   net_rx_data/net_rx_val/net_rx_en : from network output port NODE_ID
//   snk_data/snk_val/snk_rdy         : local sink (RX out)
//   tx_count, rx_count               : saturating transfer counters
//   last_latency                     : arrival time - packet timestamp
//   misroute                         : sticky, packet with dest != NODE_ID
//   dbg_rx_state                     : RX holding-register state
// Link handshake (all three links): a transfer happens on a rising edge
// exactly when the sender's valid and the receiver's ready/enable are both
// high. Valid never depends on ready; the only combinational path through
// this block is snk_rdy -> net_rx_en.
// ---------------------------------------------------------------------------
module enoc_node_interface
    import enoc_pkg::*;
#(
    parameter int NODE_ID    = 0,
    parameter int TX_DEPTH   = 4,
    parameter int DATA_WIDTH = enoc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = enoc_pkg::ADDR_WIDTH,
    parameter int TS_WIDTH   = enoc_pkg::TS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] src_payload,
    input  logic [ADDR_WIDTH-1:0] src_dest,
    input  logic                  src_val,
    output logic                  src_rdy,
    output packet_t               net_tx_data,
    output logic                  net_tx_val,
    input  logic                  net_tx_en,
    input  packet_t               net_rx_data,
    input  logic                  net_rx_val,
    output logic                  net_rx_en,
    output packet_t               snk_data,
    output logic                  snk_val,
    input  logic                  snk_rdy,
    output logic [31:0]           tx_count,
    output logic [31:0]           rx_count,
    output logic [TS_WIDTH-1:0]   last_latency,
    output logic                  misroute,
    output rx_state_e             dbg_rx_state
);

    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(NODE_ID);

    // ---------------- timebase ----------------
    logic [TS_WIDTH-1:0] time_q, time_d;

    // ---------------- TX half ----------------
    packet_t tx_entry, tx_head;
    logic    tx_full, tx_empty, tx_push, tx_pop;
    logic [31:0] tx_count_q, tx_count_d;

    assign src_rdy    = !tx_full;
    assign tx_push    = src_val && src_rdy;
    assign net_tx_val = !tx_empty;
    assign tx_pop     = net_tx_val && net_tx_en;
    // Mask the stale head so the link reads zero whenever nothing is offered.
    assign net_tx_data = tx_empty ? '0 : tx_head;

    always_comb begin
        tx_entry           = '0;
        tx_entry.data      = src_payload;
        tx_entry.source    = MY_ADDR;
        tx_entry.dest      = src_dest;
        tx_entry.timestamp = time_q;
    end

    enoc_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (tx_entry),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // ---------------- RX half ----------------
    rx_state_e           rx_state_q, rx_state_d;
    packet_t             rx_data_q, rx_data_d;
    logic                rx_load;
    logic [31:0]         rx_count_q, rx_count_d;
    logic [TS_WIDTH-1:0] last_latency_q, last_latency_d;
    logic                misroute_q, misroute_d;

    // A full register can still accept when the sink drains it this edge.
    assign net_rx_en = (rx_state_q == RX_EMPTY) || snk_rdy;
    assign rx_load   = net_rx_val && net_rx_en;

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_data_d      = rx_data_q;
        rx_count_d     = rx_count_q;
        last_latency_d = last_latency_q;
        misroute_d     = misroute_q;
        case (rx_state_q)
            RX_EMPTY: begin
                if (rx_load) rx_state_d = RX_FULL;
            end
            RX_FULL: begin
                if (snk_rdy && !net_rx_val) rx_state_d = RX_EMPTY;
            end
            default: rx_state_d = RX_EMPTY;
        endcase
        if (rx_load) begin
            rx_data_d      = net_rx_data;
            rx_count_d     = (rx_count_q == 32'hFFFF_FFFF) ? rx_count_q : rx_count_q + 32'd1;
            last_latency_d = time_q - net_rx_data.timestamp;  // modulo 2^TS_WIDTH
            if (net_rx_data.dest != MY_ADDR) misroute_d = 1'b1;
        end
    end

    // ---------------- counters / timebase ----------------
    always_comb begin
        time_d     = time_q + 1'b1;
        tx_count_d = tx_count_q;
        if (tx_pop && (tx_count_q != 32'hFFFF_FFFF)) begin
            tx_count_d = tx_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_q         <= '0;
            tx_count_q     <= '0;
            rx_state_q     <= RX_EMPTY;
            rx_data_q      <= '0;
            rx_count_q     <= '0;
            last_latency_q <= '0;
            misroute_q     <= 1'b0;
        end else begin
            time_q         <= time_d;
            tx_count_q     <= tx_count_d;
            rx_state_q     <= rx_state_d;
            rx_data_q      <= rx_data_d;
            rx_count_q     <= rx_count_d;
            last_latency_q <= last_latency_d;
            misroute_q     <= misroute_d;
        end
    end

    assign snk_val      = (rx_state_q == RX_FULL);
    assign snk_data     = rx_data_q;
    assign tx_count     = tx_count_q;
    assign rx_count     = rx_count_q;
    assign last_latency = last_latency_q;
    assign misroute     = misroute_q;
    assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_enoc_node_interface.sv
// ---------------------------------------------------------------------------
// tb_enoc_node_interface
// Randomized and directed stimulus against a queue-based reference model of
// the node interface (NODE_ID=5, TX_DEPTH=4).
// ---------------------------------------------------------------------------
module tb_enoc_node_interface;
    import enoc_pkg::*;

    localparam int NODE = 5;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] src_payload;
    logic [5:0]  src_dest;
    logic        src_val, src_rdy;
    packet_t     net_tx_data, net_rx_data, snk_data;
    logic        net_tx_val, net_tx_en, net_rx_val, net_rx_en;
    logic        snk_val, snk_rdy;
    logic [31:0] tx_count, rx_count;
    logic [15:0] last_latency;
    logic        misroute;
    rx_state_e   dbg_rx_state;

    enoc_node_interface #(.NODE_ID(NODE), .TX_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_payload  (src_payload),
        .src_dest     (src_dest),
        .src_val      (src_val),
        .src_rdy      (src_rdy),
        .net_tx_data  (net_tx_data),
        .net_tx_val   (net_tx_val),
        .net_tx_en    (net_tx_en),
        .net_rx_data  (net_rx_data),
        .net_rx_val   (net_rx_val),
        .net_rx_en    (net_rx_en),
        .snk_data     (snk_data),
        .snk_val      (snk_val),
        .snk_rdy      (snk_rdy),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .last_latency (last_latency),
        .misroute     (misroute),
        .dbg_rx_state (dbg_rx_state)
    );

    // ---------------- reference model ----------------
    packet_t     tx_exp_q[$];   // packets waiting in the TX buffer, head first
    packet_t     exp_q[$];      // packets accepted from network, not yet delivered
    logic [31:0] tx_cnt_m, rx_cnt_m;
    logic [15:0] time_m, lat_m;
    logic        mis_m;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_exp_q.delete();
        exp_q.delete();
        tx_cnt_m = 0;
        rx_cnt_m = 0;
        time_m   = 0;
        lat_m    = 0;
        mis_m    = 1'b0;
    endtask

    task automatic compare_model();
        chk("src_rdy", src_rdy, tx_exp_q.size() < DEPTH);
        chk("net_tx_val", net_tx_val, tx_exp_q.size() != 0);
        if (tx_exp_q.size() != 0) chk("net_tx_data", net_tx_data, tx_exp_q[0]);
        chk("net_rx_en", net_rx_en, (exp_q.size() == 0) || snk_rdy);
        chk("snk_val", snk_val, exp_q.size() != 0);
        chk("rx_state", dbg_rx_state == RX_FULL, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("snk_data", snk_data, exp_q[0]);
        chk("tx_count", tx_count, tx_cnt_m);
        chk("rx_count", rx_count, rx_cnt_m);
        chk("last_latency", last_latency, lat_m);
        chk("misroute", misroute, mis_m);
    endtask

    // Apply the effect of the coming rising edge to the model.
    task automatic model_step();
        int n;
        bit rx_en;
        packet_t p;
        n = tx_exp_q.size();
        if (n > 0 && net_tx_en) begin
            void'(tx_exp_q.pop_front());
            if (tx_cnt_m != 32'hFFFF_FFFF) tx_cnt_m++;
        end
        if (src_val && n < DEPTH) begin
            p.data = src_payload;
            p.source = 6'(NODE);
            p.dest = src_dest;
            p.timestamp = time_m;
            tx_exp_q.push_back(p);
        end
        rx_en = (exp_q.size() == 0) || snk_rdy;
        if (exp_q.size() != 0 && snk_rdy) void'(exp_q.pop_front());
        if (net_rx_val && rx_en) begin
            exp_q.push_back(net_rx_data);
            if (rx_cnt_m != 32'hFFFF_FFFF) rx_cnt_m++;
            lat_m = time_m - net_rx_data.timestamp;
            if (net_rx_data.dest != 6'(NODE)) mis_m = 1'b1;
        end
        time_m = time_m + 16'd1;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        compare_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        src_val = 0; src_payload = 0; src_dest = 0;
        net_tx_en = 0; net_rx_val = 0; net_rx_data = '0; snk_rdy = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_src_rdy", src_rdy, 1'b1);
        chk("rst_net_tx_val", net_tx_val, 1'b0);
        chk("rst_net_tx_data", net_tx_data, 64'd0);
        chk("rst_snk_val", snk_val, 1'b0);
        chk("rst_snk_data", snk_data, 64'd0);
        chk("rst_misroute", misroute, 1'b0);
        chk("rst_tx_count", tx_count, 64'd0);
        compare_model();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] d, input logic [5:0] dst, input logic [15:0] ts);
        net_rx_val = 1'b1;
        net_rx_data.data = d;
        net_rx_data.source = 6'd1;
        net_rx_data.dest = dst;
        net_rx_data.timestamp = ts;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            src_val     = ($urandom_range(0, 99) < 60);
            src_payload = $urandom;
            src_dest    = 6'($urandom_range(0, 63));
            net_tx_en   = ($urandom_range(0, 99) < 50);
            snk_rdy     = ($urandom_range(0, 99) < 60);
            net_rx_val  = ($urandom_range(0, 99) < 50);
            net_rx_data.data      = $urandom;
            net_rx_data.source    = 6'($urandom_range(0, 63));
            net_rx_data.dest      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'(NODE);
            net_rx_data.timestamp = 16'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset then idle.
        tick();
        chk("idle_net_rx_en", net_rx_en, 1'b1);
        chk("idle_rx_count", rx_count, 64'd0);

        // Fill the TX buffer with the network stalled, then one ignored push.
        src_val = 1'b1; src_dest = 6'd2;
        for (int i = 0; i < 4; i++) begin
            src_payload = 32'hA0 + 32'(i);
            tick();
        end
        chk("fill_src_rdy", src_rdy, 1'b0);
        src_payload = 32'hA4;
        tick();
        src_val = 1'b0;
        net_tx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_data", net_tx_data.data, 32'hA0 + 32'(i));
            chk("drain_source", net_tx_data.source, 6'd5);
            tick();
        end
        chk("drain_tx_count", tx_count, 64'd4);
        chk("drain_empty", net_tx_val, 1'b0);
        net_tx_en = 1'b0;

        // Push at time_q=100, then toggle the network enable.
        while (time_m != 16'd100) tick();
        src_val = 1'b1; src_dest = 6'd3; src_payload = 32'hB0;
        tick();
        src_payload = 32'hB1;
        tick();
        src_val = 1'b0;
        chk("ts_100", net_tx_data.timestamp, 16'd100);
        for (int i = 0; i < 8; i++) begin
            net_tx_en = i[0];
            tick();
        end
        net_tx_en = 1'b0;

        // Latency across the timestamp wrap.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        snk_rdy = 1'b1;
        send_rx(32'hC0, 6'd5, 16'hFFFE);
        tick();
        net_rx_val = 1'b0;
        chk("lat_wrap", last_latency, 16'd5);
        chk("lat_rx_count", rx_count, 64'd1);
        chk("lat_misroute", misroute, 1'b0);
        chk("lat_snk_val", snk_val, 1'b1);
        tick();

        // Sink back-pressure with back-to-back arrivals.
        snk_rdy = 1'b0;
        send_rx(32'hD1, 6'd5, 16'd0);
        tick();
        #1;
        chk("bp_net_rx_en", net_rx_en, 1'b0);
        send_rx(32'hD2, 6'd5, 16'd1);
        tick();
        tick();
        chk("bp_hold_first", snk_data.data, 32'hD1);
        snk_rdy = 1'b1;
        tick();
        net_rx_val = 1'b0;
        chk("bp_second", snk_data.data, 32'hD2);
        tick();
        chk("bp_drained", snk_val, 1'b0);

        // Misrouted packet is still delivered and the flag sticks.
        send_rx(32'hE7, 6'd7, 16'd0);
        tick();
        net_rx_val = 1'b0;
        chk("mis_delivered", snk_data.data, 32'hE7);
        chk("mis_flag", misroute, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("mis_sticky", misroute, 1'b1);

        // Random traffic, then a reset with packets buffered.
        random_cycles(400);
        src_val = 1'b1; src_payload = 32'hF0; src_dest = 6'd5;
        tick();
        tick();
        src_val = 1'b0;
        chk("pre_rst_tx_val", net_tx_val, 1'b1);
        do_reset();
        random_cycles(150);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
